// File: rtl/trace_pkg.sv
// Shared types for the trace capture block: FSM state encoding.
package trace_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StPost   = 2'd2,
    StFrozen = 2'd3
  } trace_state_t;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port, no reset on the array.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 24
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one entry per write-enabled cycle.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trace_capture.sv
// Circular trace buffer for CPU pc and watched registers: arm, trigger, post-capture, freeze,
// then drain oldest-first over a valid/ready port.
// Optional build macro TRACE_CHANGE_FILTER_EN: only capture cycles whose sample differs from
// the last captured entry.
module trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH = 8,
  parameter int unsigned PC_WIDTH       = 8,
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned POST_COUNT     = 4
) (
  input  logic                               clock,
  input  logic                               isResetN,
  input  logic                               captureEnable,
  input  logic                               trigger,
  input  logic [PC_WIDTH-1:0]                pc,
  input  logic [CHANNELS*REGISTER_WIDTH-1:0] regValues,
  input  logic                               readReady,
  output logic                               readValid,
  output logic [PC_WIDTH-1:0]                readPc,
  output logic [CHANNELS*REGISTER_WIDTH-1:0] readRegs,
  output logic [$clog2(DEPTH+1)-1:0]         entryCount,
  output logic                               wrapped,
  output logic [1:0]                         state
);

  localparam int unsigned RegsW  = CHANNELS * REGISTER_WIDTH;
  localparam int unsigned EntryW = PC_WIDTH + RegsW;
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned PostW  = (POST_COUNT > 0) ? $clog2(POST_COUNT + 1) : 1;

  if (POST_COUNT > DEPTH - 1) begin : g_bad_post_count
    $error("POST_COUNT must not exceed DEPTH-1");
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 4");
  end

  trace_state_t     state_q, state_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic [PostW-1:0] post_left_q, post_left_d;
  logic             capture;
  logic             clear;
  logic             qualified;
  logic [EntryW-1:0] wr_data;
  logic [EntryW-1:0] rd_data;

  assign wr_data = {pc, regValues};

`ifdef TRACE_CHANGE_FILTER_EN
  logic [EntryW-1:0] last_q;
  logic              first_q;

  assign qualified = first_q || (wr_data != last_q);

  // Remember the last captured sample; the first armed cycle always qualifies.
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      last_q  <= '0;
      first_q <= 1'b1;
    end else if (state_q == StIdle) begin
      first_q <= 1'b1;
    end else if (capture) begin
      first_q <= 1'b0;
      last_q  <= wr_data;
    end
  end
`else
  assign qualified = 1'b1;
`endif

  // FSM next state, capture decision and pointer/count bookkeeping.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wrapped_d   = wrapped_q;
    post_left_d = post_left_q;
    capture     = 1'b0;
    clear       = 1'b0;

    unique case (state_q)
      StIdle: begin
        clear = 1'b1;
        if (captureEnable) state_d = StArmed;
      end
      StArmed: begin
        if (trigger) begin
          // Trigger sample is always stored, filter or not.
          capture = 1'b1;
          if (POST_COUNT == 0) begin
            state_d = StFrozen;
          end else begin
            state_d     = StPost;
            post_left_d = PostW'(POST_COUNT);
          end
        end else if (!captureEnable) begin
          state_d = StIdle;
          clear   = 1'b1;
        end else begin
          capture = qualified;
        end
      end
      StPost: begin
        if (!captureEnable) begin
          state_d = StIdle;
          clear   = 1'b1;
        end else if (qualified) begin
          capture     = 1'b1;
          post_left_d = post_left_q - PostW'(1);
          if (post_left_q == PostW'(1)) state_d = StFrozen;
        end
      end
      StFrozen: begin
        if (count_q == '0) begin
          state_d = StIdle;
          clear   = 1'b1;
        end else if (readReady) begin
          rd_ptr_d = rd_ptr_q + PtrW'(1);
          count_d  = count_q - CntW'(1);
          if (count_q == CntW'(1)) begin
            state_d = StIdle;
            clear   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      // A write while full overwrites the oldest entry.
      if (count_q == CntW'(DEPTH)) begin
        rd_ptr_d  = rd_ptr_q + PtrW'(1);
        wrapped_d = 1'b1;
      end else begin
        count_d = count_q + CntW'(1);
      end
    end

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      wrapped_d   = 1'b0;
      post_left_d = '0;
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      post_left_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wrapped_q   <= wrapped_d;
      post_left_q <= post_left_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_ram (
    .clock   (clock),
    .wr_en   (capture),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Read data is only exposed while frozen; stale buffer contents stay hidden otherwise.
  always_comb begin
    readValid = (state_q == StFrozen) && (count_q != '0);
    readPc    = '0;
    readRegs  = '0;
    if (state_q == StFrozen) begin
      readPc   = rd_data[EntryW-1 -: PC_WIDTH];
      readRegs = rd_data[RegsW-1:0];
    end
  end

  assign entryCount = count_q;
  assign wrapped    = wrapped_q;
  assign state      = state_q;

endmodule

// File: doc/trace_capture.md
# trace_capture

Parametrised on-chip trace buffer that records CPU program counter and watched register values into a circular buffer. It is armed by the board switch, freezes a configurable number of samples after a trigger, and is then drained over a valid/ready read port. It sits beside `CPU` and taps the same `pc` and register-value signals the simulation bench prints, so the same trace is available in hardware.

## Interface

Parameters:
- `REGISTER_WIDTH`, 8: width of one watched register value.
- `PC_WIDTH`, 8: program counter width.
- `CHANNELS`, 2: number of watched registers.
- `DEPTH`, 16: buffer entries; power of two, ≥4.
- `POST_COUNT`, 4: samples kept after the trigger sample; must be ≤ `DEPTH-1`, checked at elaboration.

Ports:
- `clock`, in, 1: single clock; all logic is on the rising edge.
- `isResetN`, in, 1: asynchronous, active-low reset.
- `captureEnable`, in, 1: level arm, driven from `switch`.
- `trigger`, in, 1: trigger pulse; sampled only in ARMED.
- `pc`, in, `PC_WIDTH`: CPU program counter.
- `regValues`, in, `CHANNELS*REGISTER_WIDTH`: channel *k* occupies bits `[k*REGISTER_WIDTH +: REGISTER_WIDTH]`.
- `readReady`, in, 1: consumer accepts the current entry.
- `readValid`, out, 1: an entry is presented.
- `readPc`, out, `PC_WIDTH`: PC of the presented entry.
- `readRegs`, out, `CHANNELS*REGISTER_WIDTH`: register values of the presented entry.
- `entryCount`, out, `$clog2(DEPTH+1)`: entries currently held.
- `wrapped`, out, 1: at least one entry was overwritten since arming.
- `state`, out, 2: current FSM state.

## Operation

States and encodings:
- IDLE=0
- ARMED=1
- POST=2
- FROZEN=3

Transitions:
- **IDLE:**
  - Pointers, count and `wrapped` are held at zero.
  - `captureEnable`=1 moves the block to ARMED on the next cycle. No capture happens in the IDLE cycle.
- **ARMED:**
  - Each capture-qualified cycle writes `{pc, regValues}` at `wrPtr`, and `wrPtr` increments modulo `DEPTH`.
  - `entryCount` saturates at `DEPTH`.
  - A write while full overwrites the oldest entry, advances `rdPtr` and sets `wrapped`.
  - `trigger`=1 forces a capture of that cycle as the trigger entry, regardless of the filter.
    - The block then moves to POST with `postLeft=POST_COUNT`.
    - If `POST_COUNT`=0, it moves directly to FROZEN.
  - `captureEnable`=0 (and no trigger) returns the block to IDLE and clears the buffer.
- **POST:**
  - Captures continue as in ARMED. Each capture decrements `postLeft`.
  - The capture that makes `postLeft` reach 0 moves the block to FROZEN.
  - `trigger` is ignored.
  - `captureEnable`=0 aborts to IDLE and clears the buffer.
- **FROZEN:**
  - No writes.
  - `readValid` = (`entryCount` ≠ 0). The read data is the entry at `rdPtr`, oldest first.
  - A read handshake (`readValid` && `readReady`) advances `rdPtr` and decrements `entryCount`.
  - When the last entry is accepted, the block moves to IDLE.
  - `captureEnable` and `trigger` are ignored.

Other rules:
- Simultaneous `trigger` and `captureEnable` fall in ARMED: the trigger wins and the capture happens.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally.

## Timing

- All outputs are 0 during reset and on the first cycle after release, with state=IDLE.
- Capture latency: a sample present in cycle *t* is stored at the edge ending *t*. It can be read no earlier than the first FROZEN cycle.
- `readPc`/`readRegs` are combinational from the buffer at the registered `rdPtr`. They are stable while `readValid` is high and `readReady` is low.
- Maximum throughput is one entry per cycle with `readReady` held high.
- `readValid`=0 in every non-FROZEN state. In those states `readPc`/`readRegs` are don't-care and are driven to 0.
- Asserting `isResetN`=0 in any state immediately clears the FSM, pointers, count and `wrapped`. Buffer contents are not cleared and never become visible.

## Configuration

- `TRACE_CHANGE_FILTER_EN`:
  - **Defined:** in ARMED/POST, a cycle is capture-qualified only if `pc` or any channel differs from the last captured entry. The first cycle in ARMED always qualifies. Filtered cycles do not decrement `postLeft`.
  - **Undefined:** every ARMED/POST cycle is capture-qualified, and no last-entry compare register exists.

## Structure

- Package `trace_pkg`: the state enum `trace_state_t` and its encodings.
- Sub-module `trace_ram`:
  - `DEPTH` × (`PC_WIDTH` + `CHANNELS*REGISTER_WIDTH`) entries.
  - One synchronous write port and one asynchronous read port.
  - No reset on the array.
- The top level holds the FSM, pointers, counters and the optional filter.

## Test plan

Defaults apply unless stated (`DEPTH`=16, `POST_COUNT`=4, `CHANNELS`=2).

1. Hold `isResetN`=0 for 3 cycles, then release → state=0, `readValid`=0, `entryCount`=0, `wrapped`=0.
2. Filter off; `pc` counts from 0 starting at the first ARMED cycle; pulse `trigger` when `pc`=20 → FROZEN after `pc`=24 is captured; 16 reads return `pc` 9..24 in order; `wrapped`=1.
3. Filter off; pulse `trigger` at `pc`=2 → 7 entries, `pc` 0..6; `wrapped`=0; state returns to IDLE after the 7th accept.
4. In FROZEN, hold `readReady`=0 for 5 cycles → `readValid`=1 with constant data; then toggle `readReady` every other cycle → one entry accepted per high cycle.
5. Drop `captureEnable` in POST with `postLeft`=2 → IDLE, `entryCount`=0. Pull `isResetN`=0 mid-FROZEN → IDLE, `readValid`=0 immediately.
6. `TRACE_CHANGE_FILTER_EN` defined:
   - `pc`=5 for 10 cycles, then 6, with `regValues` constant → 2 entries captured.
   - Changing channel 1 with `pc` held → a new entry is captured.
